// File: rtl/sobel_pkg.sv
// sobel_pkg
// Shared definitions for the Sobel front end (window generator and detector):
// default frame geometry, default coordinate widths and the window-generator
// FSM state type.
package sobel_pkg;

    localparam int PIX_W_DEF    = 8;
    localparam int IMG_ROWS_DEF = 436;
    localparam int IMG_COLS_DEF = 576;
    localparam int ROW_W_DEF    = $clog2(IMG_ROWS_DEF);
    localparam int COL_W_DEF    = $clog2(IMG_COLS_DEF);

    // FILL: rows 0/1 still being collected; RUN: windows being produced;
    // FLUSH: last pixel of the frame taken, final window not yet consumed.
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } win_state_e;

endpackage

// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if
// Pixel-in / window-out stream bundle of the 3x3 window generator.
//   in_pix/in_valid/in_sof/in_ready : raster pixel stream (valid/ready)
//   z1..z9                           : 3x3 window, row-major, z5 = centre
//   out_valid/out_ready              : window stream handshake
//   win_row/win_col/win_last         : centre coordinates, last-window flag
// master = stream source/sink side, slave = window generator.
interface sobel_window_gen_if
    import sobel_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int ROW_W = ROW_W_DEF,
    parameter int COL_W = COL_W_DEF
);
    logic [PIX_W-1:0] in_pix;
    logic             in_valid;
    logic             in_sof;
    logic             in_ready;
    logic [PIX_W-1:0] z1, z2, z3, z4, z5, z6, z7, z8, z9;
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] win_row;
    logic [COL_W-1:0] win_col;
    logic             win_last;

    modport master (
        output in_pix, in_valid, in_sof, out_ready,
        input  in_ready, z1, z2, z3, z4, z5, z6, z7, z8, z9,
        input  out_valid, win_row, win_col, win_last
    );

    modport slave (
        input  in_pix, in_valid, in_sof, out_ready,
        output in_ready, z1, z2, z3, z4, z5, z6, z7, z8, z9,
        output out_valid, win_row, win_col, win_last
    );
endinterface

// File: rtl/sobel_line_buf.sv
// sobel_line_buf
// One image line of storage. Read is combinational at addr so that the old
// contents are seen in the same cycle the new value is written
// (read-before-write). Contents are intentionally not reset.
//   clk   : clock
//   we    : write enable
//   addr  : column address (read and write)
//   wdata : value written at addr on the rising edge when we=1
//   rdata : current contents at addr
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_COLS_DEF,
    parameter int WIDTH = PIX_W_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Line storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen
// Builds 3x3 neighbourhoods from a raster pixel stream for the Sobel detector.
// Two line buffers hold the previous two lines; a 3x3 shift window takes one
// new column per accepted pixel. Interior windows are registered into the
// output stage on the accept edge (latency 1) together with centre coordinates.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   sw    : stream bundle (slave side), see sobel_window_gen_if
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_ROWS = IMG_ROWS_DEF,
    parameter int IMG_COLS = IMG_COLS_DEF,
    parameter int PIX_W    = PIX_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    sobel_window_gen_if.slave    sw
);

    localparam int ROW_W = $clog2(IMG_ROWS);
    localparam int COL_W = $clog2(IMG_COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COLS - 1);

    logic             in_ready_s;
    logic             acc_s;
    logic             consume_s;
    logic             emit_s;
    logic             last_pix_s;
    logic [ROW_W-1:0] row_r, pos_row_s, row_nxt_s;
    logic [COL_W-1:0] col_r, pos_col_s, col_nxt_s;
    logic [PIX_W-1:0] lb0_rd_s, lb1_rd_s;
    logic [PIX_W-1:0] win_r     [9];
    logic [PIX_W-1:0] win_nxt_s [9];
    logic [PIX_W-1:0] z_r       [9];
    logic             out_valid_r;
    logic             win_last_r;
    logic [ROW_W-1:0] win_row_r;
    logic [COL_W-1:0] win_col_r;
    win_state_e       state_r, state_nxt_s, acc_state_s;

    // The only stall source is an unconsumed window in the output register.
    assign in_ready_s = !out_valid_r || sw.out_ready;
    assign acc_s      = sw.in_valid && in_ready_s;
    assign consume_s  = out_valid_r && sw.out_ready;

    // Position of the pixel being accepted and the counter value after it;
    // in_sof forces (0,0) so a partial frame is abandoned.
    always_comb begin
        pos_row_s = row_r;
        pos_col_s = col_r;
        if (sw.in_sof) begin
            pos_row_s = {ROW_W{1'b0}};
            pos_col_s = {COL_W{1'b0}};
        end else begin
            pos_row_s = row_r;
            pos_col_s = col_r;
        end

        row_nxt_s = pos_row_s;
        col_nxt_s = pos_col_s + COL_W'(1);
        if (pos_col_s == COL_LAST) begin
            col_nxt_s = {COL_W{1'b0}};
            if (pos_row_s == ROW_LAST) begin
                row_nxt_s = {ROW_W{1'b0}};
            end else begin
                row_nxt_s = pos_row_s + ROW_W'(1);
            end
        end else begin
            col_nxt_s = pos_col_s + COL_W'(1);
            row_nxt_s = pos_row_s;
        end

        last_pix_s = (pos_row_s == ROW_LAST) && (pos_col_s == COL_LAST);
        // Only interior centres produce a window: needs two lines above and
        // two columns to the left of the accepted pixel.
        emit_s     = acc_s && (pos_row_s >= ROW_W'(2)) && (pos_col_s >= COL_W'(2));
    end

    sobel_line_buf #(.DEPTH(IMG_COLS), .WIDTH(PIX_W), .AW(COL_W)) u_lb0 (
        .clk   (clk),
        .we    (acc_s),
        .addr  (pos_col_s),
        .wdata (sw.in_pix),
        .rdata (lb0_rd_s)
    );

    // lb1 receives the line that is leaving lb0 at the same column.
    sobel_line_buf #(.DEPTH(IMG_COLS), .WIDTH(PIX_W), .AW(COL_W)) u_lb1 (
        .clk   (clk),
        .we    (acc_s),
        .addr  (pos_col_s),
        .wdata (lb0_rd_s),
        .rdata (lb1_rd_s)
    );

    // Next window: shift one column left, new right column from the lines.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            win_nxt_s[i*3 + 0] = win_r[i*3 + 1];
            win_nxt_s[i*3 + 1] = win_r[i*3 + 2];
        end
        win_nxt_s[2] = lb1_rd_s;
        win_nxt_s[5] = lb0_rd_s;
        win_nxt_s[8] = sw.in_pix;
    end

    // Position counters and shift window, advanced on every accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_r <= {ROW_W{1'b0}};
            col_r <= {COL_W{1'b0}};
            for (int i = 0; i < 9; i++) begin
                win_r[i] <= {PIX_W{1'b0}};
            end
        end else if (acc_s) begin
            row_r <= row_nxt_s;
            col_r <= col_nxt_s;
            for (int i = 0; i < 9; i++) begin
                win_r[i] <= win_nxt_s[i];
            end
        end
    end

    // Output register: loaded with the new window on an interior accept,
    // held while stalled, emptied on consume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
            win_row_r   <= {ROW_W{1'b0}};
            win_col_r   <= {COL_W{1'b0}};
            for (int i = 0; i < 9; i++) begin
                z_r[i] <= {PIX_W{1'b0}};
            end
        end else if (emit_s) begin
            out_valid_r <= 1'b1;
            win_last_r  <= last_pix_s;
            win_row_r   <= pos_row_s - ROW_W'(1);
            win_col_r   <= pos_col_s - COL_W'(1);
            for (int i = 0; i < 9; i++) begin
                z_r[i] <= win_nxt_s[i];
            end
        end else if (consume_s) begin
            out_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
        end
    end

    // FSM next state. An accept decides the state from the pixel position;
    // FLUSH otherwise waits for the last window to be taken.
    always_comb begin
        acc_state_s = ST_FILL;
        if (last_pix_s) begin
            acc_state_s = ST_FLUSH;
        end else if (row_nxt_s >= ROW_W'(2)) begin
            acc_state_s = ST_RUN;
        end else begin
            acc_state_s = ST_FILL;
        end

        state_nxt_s = state_r;
        case (state_r)
            ST_FILL, ST_RUN: begin
                if (acc_s) begin
                    state_nxt_s = acc_state_s;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_FLUSH: begin
                if (acc_s) begin
                    state_nxt_s = acc_state_s;
                end else if (consume_s && win_last_r) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_FILL;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign sw.in_ready  = in_ready_s;
    assign sw.out_valid = out_valid_r;
    assign sw.win_last  = win_last_r;
    assign sw.win_row   = win_row_r;
    assign sw.win_col   = win_col_r;
    assign sw.z1 = z_r[0];
    assign sw.z2 = z_r[1];
    assign sw.z3 = z_r[2];
    assign sw.z4 = z_r[3];
    assign sw.z5 = z_r[4];
    assign sw.z6 = z_r[5];
    assign sw.z7 = z_r[6];
    assign sw.z8 = z_r[7];
    assign sw.z9 = z_r[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen
// Directed bench for sobel_window_gen on a 4x5 frame with pixel = 16*r + c.
// Expected windows are a hand-computed table; windows seen on the output are
// checked in order against it.
module tb_sobel_window_gen;

    localparam int ROWS = 4;
    localparam int COLS = 5;

    typedef struct {
        logic [1:0]        row;
        logic [2:0]        col;
        logic              last;
        logic [0:8][7:0]   z;
    } win_vec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sobel_window_gen_if #(.PIX_W(8), .ROW_W(2), .COL_W(3)) sw ();

    sobel_window_gen #(.IMG_ROWS(ROWS), .IMG_COLS(COLS), .PIX_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    win_vec_t exp_tab [6];
    int n_checks  = 0;
    int n_fail    = 0;
    int win_cnt   = 0;
    int base_cnt  = 0;
    int n_last    = 0;
    int base_last = 0;
    bit gap_en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [0:8][7:0] zvec();
        return {sw.z1, sw.z2, sw.z3, sw.z4, sw.z5, sw.z6, sw.z7, sw.z8, sw.z9};
    endfunction

    task automatic set_exp(input int i, input logic [1:0] r, input logic [2:0] c,
                           input logic l, input logic [0:8][7:0] z);
        exp_tab[i].row  = r;
        exp_tab[i].col  = c;
        exp_tab[i].last = l;
        exp_tab[i].z    = z;
    endtask

    // Checks every consumed window against the table, in order.
    task automatic monitor_loop();
        logic [0:8][7:0] act;
        int idx;
        forever begin
            @(negedge clk);
            if (!reset && sw.out_valid && sw.out_ready) begin
                act = zvec();
                idx = (win_cnt - base_cnt) % 6;
                for (int k = 0; k < 9; k++) begin
                    chk($sformatf("win%0d_z%0d", win_cnt - base_cnt, k + 1),
                        32'(act[k]), 32'(exp_tab[idx].z[k]));
                end
                chk($sformatf("win%0d_row", win_cnt - base_cnt), 32'(sw.win_row), 32'(exp_tab[idx].row));
                chk($sformatf("win%0d_col", win_cnt - base_cnt), 32'(sw.win_col), 32'(exp_tab[idx].col));
                chk($sformatf("win%0d_last", win_cnt - base_cnt), 32'(sw.win_last), 32'(exp_tab[idx].last));
                if (sw.win_last) n_last++;
                win_cnt++;
            end
        end
    endtask

    // Presents one pixel and returns just after the edge that accepted it.
    task automatic send(input logic [7:0] pix, input bit sof);
        int  waitc;
        bit  acc;
        if (gap_en) begin
            sw.in_valid = 1'b0;
            sw.in_sof   = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        sw.in_pix   = pix;
        sw.in_sof   = sof;
        sw.in_valid = 1'b1;
        waitc = 0;
        acc   = 1'b0;
        while (!acc && waitc < 50) begin
            @(negedge clk);
            acc = sw.in_ready;
            @(posedge clk);
            #1;
            waitc++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: pixel 0x%0h not accepted within 50 cycles", pix);
        end
        sw.in_valid = 1'b0;
        sw.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input bit first_sof, input logic [7:0] offs, input int n_pix);
        for (int i = 0; i < n_pix; i++) begin
            send(8'((16 * (i / COLS)) + (i % COLS)) + offs, first_sof && (i == 0));
        end
    endtask

    task automatic begin_test();
        base_cnt  = win_cnt;
        base_last = n_last;
    endtask

    task automatic end_test(input string name, input int exp_n, input int exp_last);
        repeat (6) @(posedge clk);
        #1;
        chk({name, "_windows"}, 32'(win_cnt - base_cnt), 32'(exp_n));
        chk({name, "_lasts"}, 32'(n_last - base_last), 32'(exp_last));
    endtask

    // Holds out_ready low for three cycles on the first window.
    task automatic stall_proc();
        logic [0:8][7:0] snap;
        int k;
        k = 0;
        while (!sw.out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("stall_seen", 32'(sw.out_valid), 32'd1);
        snap = zvec();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("stall%0d_valid", i), 32'(sw.out_valid), 32'd1);
            chk($sformatf("stall%0d_in_ready", i), 32'(sw.in_ready), 32'd0);
            chk($sformatf("stall%0d_z_stable", i), 32'(zvec() == snap), 32'd1);
            chk($sformatf("stall%0d_z5", i), 32'(sw.z5), 32'h11);
            chk($sformatf("stall%0d_col", i), 32'(sw.win_col), 32'd1);
        end
        @(posedge clk);
        #1;
        sw.out_ready = 1'b1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        reset        = 1'b1;
        sw.in_valid  = 1'b0;
        sw.in_sof    = 1'b0;
        sw.in_pix    = 8'h00;
        sw.out_ready = 1'b1;

        set_exp(0, 2'd1, 3'd1, 1'b0, {8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22});
        set_exp(1, 2'd1, 3'd2, 1'b0, {8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23});
        set_exp(2, 2'd1, 3'd3, 1'b0, {8'h02, 8'h03, 8'h04, 8'h12, 8'h13, 8'h14, 8'h22, 8'h23, 8'h24});
        set_exp(3, 2'd2, 3'd1, 1'b0, {8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32});
        set_exp(4, 2'd2, 3'd2, 1'b0, {8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33});
        set_exp(5, 2'd2, 3'd3, 1'b1, {8'h12, 8'h13, 8'h14, 8'h22, 8'h23, 8'h24, 8'h32, 8'h33, 8'h34});

        fork
            monitor_loop();
        join_none

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(sw.out_valid), 32'd0);
        chk("rst_win_last", 32'(sw.win_last), 32'd0);
        chk("rst_z1", 32'(sw.z1), 32'd0);
        chk("rst_z5", 32'(sw.z5), 32'd0);
        chk("rst_z9", 32'(sw.z9), 32'd0);
        chk("rst_win_row", 32'(sw.win_row), 32'd0);
        chk("rst_win_col", 32'(sw.win_col), 32'd0);
        chk("rst_in_ready", 32'(sw.in_ready), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full frame, no back-pressure.
        begin_test();
        send_frame(1'b1, 8'h00, 20);
        end_test("full", 6, 1);

        // Three-cycle stall on the first window.
        sw.out_ready = 1'b0;
        begin_test();
        fork
            send_frame(1'b1, 8'h00, 20);
            stall_proc();
        join
        end_test("stall", 6, 1);

        // Random idle gaps between pixels.
        gap_en = 1'b1;
        begin_test();
        send_frame(1'b1, 8'h00, 20);
        end_test("gaps", 6, 1);
        gap_en = 1'b0;

        // Partial frame cut at (2,1) by a new in_sof.
        begin_test();
        send_frame(1'b1, 8'h80, 11);
        send_frame(1'b1, 8'h00, 20);
        end_test("sof_restart", 6, 1);

        // Reset pulse right after pixel (2,3); next frame without in_sof.
        begin_test();
        send_frame(1'b1, 8'h00, 14);
        chk("midrst_pre_windows", 32'(win_cnt - base_cnt), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(sw.out_valid), 32'd0);
        chk("midrst_win_last", 32'(sw.win_last), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        begin_test();
        send_frame(1'b0, 8'h00, 20);
        end_test("after_rst", 6, 1);

        // Two back-to-back frames, counter wrap into the second frame.
        begin_test();
        send_frame(1'b1, 8'h00, 20);
        send_frame(1'b0, 8'h00, 20);
        end_test("b2b", 12, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 Parameter IMG_ROWS, default 436, frame height in pixels (minimum 3).
REQ-002 Parameter IMG_COLS, default 576, frame width in pixels (minimum 3).
REQ-003 Parameter PIX_W, default 8, pixel width in bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_pix  input  PIX_W  raster-order pixel, row-major, left to right.
REQ-007 in_valid  input  1  in_pix is valid this cycle.
REQ-008 in_sof  input  1  qualifies in_pix as pixel (0,0) of a new frame.
REQ-009 in_ready  output  1  block accepts in_pix this cycle.
REQ-010 z1..z9  output  PIX_W each  3x3 window in row-major order: z1..z3 top row, z4..z6 centre row, z5 centre pixel, z7..z9 bottom row; left to right within each row.
REQ-011 out_valid  output  1  window and coordinates are valid.
REQ-012 out_ready  input  1  downstream consumes the window this cycle.
REQ-013 win_row, win_col  output  clog2(IMG_ROWS), clog2(IMG_COLS)  centre-pixel coordinates of the window.
REQ-014 win_last  output  1  window is the last one of the frame; centre is (IMG_ROWS-2, IMG_COLS-2).

Function
REQ-015 A pixel is accepted when in_valid && in_ready; a window is consumed when out_valid && out_ready.
REQ-016 in_ready = !out_valid || out_ready, combinationally; no other stall source exists.
REQ-017 Column counter c and row counter r give the position of the next accepted pixel; both start at 0.
REQ-018 On accept, c increments; at IMG_COLS-1, c wraps to 0 and r increments; at (IMG_ROWS-1, IMG_COLS-1), both wrap to 0.
REQ-019 An accepted pixel with in_sof=1 is placed at (0,0) regardless of the counters, and the counters continue from (0,1); any partial frame is discarded.
REQ-020 Two line buffers of IMG_COLS x PIX_W each, with read-before-write at address c on accept: lb1[c] <= lb0[c] and lb0[c] <= in_pix.
REQ-021 A 3x3 window register shifts one column left on each accept; the new right column is {lb1[c], lb0[c], in_pix}, top to bottom.
REQ-022 Accepting pixel (r,c) with r>=2 and c>=2 loads the output register on the same edge with the window centred at (r-1, c-1); out_valid=1 on the next cycle (latency 1).
REQ-023 Accepts with r<2 or c<2 do not assert out_valid; out_valid falls on consume unless a new window is loaded on the same edge.
REQ-024 Exactly (IMG_ROWS-2)*(IMG_COLS-2) windows per frame; border pixels produce no window; win_last is asserted exactly once per frame.
REQ-025 While out_valid=1 and out_ready=0, z1..z9, win_row, win_col and win_last are held stable.
REQ-026 An FSM with states FILL (r<2), RUN (r>=2) and FLUSH (last pixel accepted, final window pending) returns to FILL after win_last is consumed or after an in_sof accept.
REQ-027 Outputs are registered; no combinational path exists from in_pix to z1..z9.

Reset
REQ-028 On reset: out_valid=0, win_last=0, z1..z9=0, win_row=0, win_col=0, counters=0, FSM=FILL.
REQ-029 Reset asserted mid-frame discards the frame; the first accept after reset is treated as pixel (0,0).
REQ-030 Line-buffer contents are not reset; they are never exposed before being rewritten in the current frame.

Structure
REQ-031 Package sobel_pkg holds the PIX_W, IMG_ROWS and IMG_COLS defaults, the coordinate widths and the FSM state enum, shared with sobel3x3det.
REQ-032 One sub-module, sobel_line_buf (IMG_COLS x PIX_W, synchronous write, read-before-write), is instantiated twice.
REQ-033 Output z1..z9 connects directly to the same-named sobel3x3det inputs.

Verification (IMG_ROWS=4, IMG_COLS=5, pixel = 16*r+c; benches run IMG_ROWS=4, IMG_COLS=5)
REQ-034 Full frame, out_ready=1 -> 6 windows; first window centre (1,1) gives z1..z9=00,01,02,10,11,12,20,21,22; last window centre (2,3) gives z9=34 and win_last=1.
REQ-035 out_ready=0 for 3 cycles on the first window -> outputs stable, in_ready=0, no pixel lost, sequence identical to REQ-034.
REQ-036 Random in_valid gaps -> window values and order identical to REQ-034.
REQ-037 in_sof asserted at pixel (2,1) of frame 1, then a full frame 2 -> no window from the partial frame, 6 correct windows from frame 2.
REQ-038 reset pulse after pixel (2,3) -> out_valid=0 next cycle; the following full frame yields the REQ-034 windows.
REQ-039 Two back-to-back frames with no gap -> 12 windows; win_last on the 6th and 12th windows only.
